pe_config_ctrl: RTL
===================

Name: pe_config_ctrl

Overview:
Second-generation PE configuration controller. Accepts configuration commands over a valid/ready stream and stages them in shadow registers for N functional units and two crossbars (CB1, CB2). On COMMIT it atomically transfers the shadow state to active registers, optionally waiting for the PE datapath to be idle. Sits between the tile instruction/config network and the PE datapath and crossbars, which consume the active outputs.

Parameters:
NUM_UNITS, 4, number of functional-unit config slots (CMAC, LOGI, CORDIC, DMEM order).
UNIT_CFG_W, 32, width of each unit config slot; bit 0 is the unit enable.
NUM_CB1_OUT, 16, CB1 output count.
NUM_CB1_IN, 14, CB1 input count; CB1_SEL_W = $clog2(NUM_CB1_IN).
NUM_CB2_OUT, 4, CB2 output count.
NUM_CB2_IN, 10, CB2 input count; CB2_SEL_W = $clog2(NUM_CB2_IN).
ADDR_W, 8, command address width.
EPOCH_W, 4, commit counter width.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when valid && ready.
cmd_op  in  2  0=WR_UNIT, 1=WR_CB1, 2=WR_CB2, 3=COMMIT.
cmd_addr  in  ADDR_W  slot/output index.
cmd_data  in  UNIT_CFG_W  payload; for COMMIT, bit0 = wait_idle.
pe_idle  in  1  datapath has no work in flight.
unit_cfg  out  NUM_UNITS*UNIT_CFG_W  active unit configs, packed, unit 0 in LSBs.
unit_en  out  NUM_UNITS  bit 0 of each active unit config.
cb1_sel  out  NUM_CB1_OUT*CB1_SEL_W  active CB1 selects.
cb2_sel  out  NUM_CB2_OUT*CB2_SEL_W  active CB2 selects.
commit_done  out  1  one-cycle pulse after an active update.
epoch  out  EPOCH_W  commit count, wraps.
cfg_err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All shadow and active registers, epoch, cfg_err and commit_done reset to 0. The FSM resets to IDLE, where cmd_ready=1.
- FSM states: IDLE and WAIT_IDLE. cmd_ready = (state==IDLE).
- WR_UNIT, accepted with addr<NUM_UNITS: shadow_unit[addr] <= cmd_data at the accept edge. Active outputs are unchanged.
- WR_CB1 / WR_CB2: shadow select for output addr <= cmd_data[SEL_W-1:0].
- Error conditions: addr >= output count, or select value >= input count. The write is dropped, cfg_err is set (sticky until reset), and the command is still consumed.
- COMMIT with wait_idle=0, or with pe_idle=1 on the accept edge: active <= shadow at that edge. epoch increments (mod 2^EPOCH_W). commit_done is high for the following cycle only. State stays IDLE.
- COMMIT with wait_idle=1 and pe_idle=0: go to WAIT_IDLE (cmd_ready=0). On the first edge where pe_idle=1: active <= shadow, epoch increments, pulse commit_done, return to IDLE.
- Latency: write to visible output = write accept + COMMIT accept edge. Outputs update at the COMMIT (or idle) edge.
- Shadow state persists after commit, so incremental reconfiguration is allowed. No ordering constraints beyond stream order.
- Back-to-back COMMITs: each one increments epoch and pulses commit_done. commit_done may stay high for consecutive cycles.
- Reset mid-WAIT_IDLE: the pending commit is discarded and everything returns to its reset values.
- Active registers never change outside a commit edge or reset.

Test Plan:
1. Reset, then check outputs: all outputs 0, cmd_ready=1, epoch=0.
2. Write and commit: WR_UNIT addr1 data 0x0000_00A5, then WR_CB1 addr3 sel 13, then COMMIT(wait=0). unit_cfg[1] and cb1_sel[3] stay 0 until the COMMIT edge, then read 0xA5 and 13. unit_en=4'b0010, commit_done pulses once, epoch=1.
3. Error handling: WR_CB1 sel 14, WR_CB2 addr 4, WR_UNIT addr 4. Shadow and active are unchanged, cfg_err=1 and stays 1 after a later valid COMMIT.
4. Wait for idle: with pe_idle=0, issue COMMIT(wait=1). cmd_ready drops and outputs hold. Raise pe_idle on cycle 5: outputs update at that edge, commit_done pulses, then cmd_ready=1.
5. Epoch wrap: 16 consecutive COMMITs take epoch 0→…→15→0, with commit_done high for 16 consecutive cycles.
6. Reset during wait: assert rst_n low while in WAIT_IDLE. Outputs clear immediately (asynchronous). After release the state is IDLE and the stale commit never applies when pe_idle rises.

Source files
------------

// File: rtl/pe_config_ctrl.sv
// PE configuration controller: stages unit and crossbar configuration in
// shadow registers and moves it to the active registers atomically on COMMIT.
module pe_config_ctrl #(
    parameter  int NUM_UNITS   = 4,
    parameter  int UNIT_CFG_W  = 32,
    parameter  int NUM_CB1_OUT = 16,
    parameter  int NUM_CB1_IN  = 14,
    parameter  int NUM_CB2_OUT = 4,
    parameter  int NUM_CB2_IN  = 10,
    parameter  int ADDR_W      = 8,
    parameter  int EPOCH_W     = 4,
    localparam int CB1_SEL_W   = $clog2(NUM_CB1_IN),
    localparam int CB2_SEL_W   = $clog2(NUM_CB2_IN)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [ADDR_W-1:0]                cmd_addr,
    input  logic [UNIT_CFG_W-1:0]            cmd_data,
    input  logic                             pe_idle,
    output logic [NUM_UNITS*UNIT_CFG_W-1:0]  unit_cfg,
    output logic [NUM_UNITS-1:0]             unit_en,
    output logic [NUM_CB1_OUT*CB1_SEL_W-1:0] cb1_sel,
    output logic [NUM_CB2_OUT*CB2_SEL_W-1:0] cb2_sel,
    output logic                             commit_done,
    output logic [EPOCH_W-1:0]               epoch,
    output logic                             cfg_err
);

    localparam int UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int C1IDX_W = (NUM_CB1_OUT > 1) ? $clog2(NUM_CB1_OUT) : 1;
    localparam int C2IDX_W = (NUM_CB2_OUT > 1) ? $clog2(NUM_CB2_OUT) : 1;

    typedef enum logic [1:0] {
        OP_UNIT   = 2'd0,
        OP_CB1    = 2'd1,
        OP_CB2    = 2'd2,
        OP_COMMIT = 2'd3
    } op_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_IDLE = 1'b1
    } state_e;

    state_e state_q;
    logic   ready_q;
    logic   commit_done_q;
    logic   cfg_err_q;
    logic [EPOCH_W-1:0] epoch_q;

    logic [UNIT_CFG_W-1:0] sh_unit_q  [NUM_UNITS];
    logic [CB1_SEL_W-1:0]  sh_cb1_q   [NUM_CB1_OUT];
    logic [CB2_SEL_W-1:0]  sh_cb2_q   [NUM_CB2_OUT];
    logic [UNIT_CFG_W-1:0] act_unit_q [NUM_UNITS];
    logic [CB1_SEL_W-1:0]  act_cb1_q  [NUM_CB1_OUT];
    logic [CB2_SEL_W-1:0]  act_cb2_q  [NUM_CB2_OUT];

    logic accept;
    logic unit_addr_ok;
    logic cb1_ok;
    logic cb2_ok;
    logic unit_wr;
    logic cb1_wr;
    logic cb2_wr;
    logic err_set;
    logic commit_now;
    logic go_wait;

    logic [UIDX_W-1:0]  uidx;
    logic [C1IDX_W-1:0] c1idx;
    logic [C2IDX_W-1:0] c2idx;

    assign uidx  = cmd_addr[UIDX_W-1:0];
    assign c1idx = cmd_addr[C1IDX_W-1:0];
    assign c2idx = cmd_addr[C2IDX_W-1:0];

    // Decode the accepted command into write, error and commit strobes.
    always_comb begin
        accept       = cmd_valid & ready_q;
        unit_addr_ok = cmd_addr < ADDR_W'(NUM_UNITS);
        cb1_ok       = (cmd_addr < ADDR_W'(NUM_CB1_OUT)) &&
                       (cmd_data < UNIT_CFG_W'(NUM_CB1_IN));
        cb2_ok       = (cmd_addr < ADDR_W'(NUM_CB2_OUT)) &&
                       (cmd_data < UNIT_CFG_W'(NUM_CB2_IN));
        unit_wr      = 1'b0;
        cb1_wr       = 1'b0;
        cb2_wr       = 1'b0;
        err_set      = 1'b0;
        commit_now   = 1'b0;
        go_wait      = 1'b0;
        if (accept) begin
            unique case (op_e'(cmd_op))
                OP_UNIT: begin
                    unit_wr = unit_addr_ok;
                    err_set = !unit_addr_ok;
                end
                OP_CB1: begin
                    cb1_wr  = cb1_ok;
                    err_set = !cb1_ok;
                end
                OP_CB2: begin
                    cb2_wr  = cb2_ok;
                    err_set = !cb2_ok;
                end
                OP_COMMIT: begin
                    commit_now = !cmd_data[0] || pe_idle;
                    go_wait    = cmd_data[0] && !pe_idle;
                end
                default: ;
            endcase
        end
        if (state_q == WAIT_IDLE && pe_idle) begin
            commit_now = 1'b1;
        end
    end

    // Shadow registers take every legal write in stream order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_unit_q <= '{default: '0};
            sh_cb1_q  <= '{default: '0};
            sh_cb2_q  <= '{default: '0};
        end else begin
            if (unit_wr) sh_unit_q[uidx] <= cmd_data;
            if (cb1_wr)  sh_cb1_q[c1idx] <= cmd_data[CB1_SEL_W-1:0];
            if (cb2_wr)  sh_cb2_q[c2idx] <= cmd_data[CB2_SEL_W-1:0];
        end
    end

    // Commit FSM: owns active state, epoch, done pulse, error flag and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            commit_done_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            epoch_q       <= '0;
            act_unit_q    <= '{default: '0};
            act_cb1_q     <= '{default: '0};
            act_cb2_q     <= '{default: '0};
        end else begin
            commit_done_q <= commit_now;
            if (err_set) cfg_err_q <= 1'b1;
            if (commit_now) begin
                act_unit_q <= sh_unit_q;
                act_cb1_q  <= sh_cb1_q;
                act_cb2_q  <= sh_cb2_q;
                epoch_q    <= epoch_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (go_wait) begin
                        state_q <= WAIT_IDLE;
                        ready_q <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    if (pe_idle) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Flatten the active arrays onto the packed output buses.
    always_comb begin
        unit_cfg = '0;
        unit_en  = '0;
        cb1_sel  = '0;
        cb2_sel  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_cfg[i*UNIT_CFG_W +: UNIT_CFG_W] = act_unit_q[i];
            unit_en[i] = act_unit_q[i][0];
        end
        for (int i = 0; i < NUM_CB1_OUT; i++) begin
            cb1_sel[i*CB1_SEL_W +: CB1_SEL_W] = act_cb1_q[i];
        end
        for (int i = 0; i < NUM_CB2_OUT; i++) begin
            cb2_sel[i*CB2_SEL_W +: CB2_SEL_W] = act_cb2_q[i];
        end
    end

    assign cmd_ready   = ready_q;
    assign commit_done = commit_done_q;
    assign epoch       = epoch_q;
    assign cfg_err     = cfg_err_q;

endmodule
